lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store unit between the execute stage and the data memory. Turns a core load/store request (RV32I funct3, byte address, rs2 data) into one or two word-aligned memory transactions with byte masks and active-low memory controls. Stalls the core while busy. Returns the load result lane-aligned and sign- or zero-extended. Accesses that cross a word boundary are split into two sequential transactions by an internal FSM.

## Interface
- No parameters (fixed 32-bit datapath, 4 byte lanes).
- clk  in  1  rising-edge clock for all state and outputs.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; sampled only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2), right-justified.
- stall  out  1  high whenever state ≠ IDLE (combinational from state).
- done  out  1  one-cycle pulse when the operation completes.
- err  out  1  one-cycle pulse, concurrent with done, for an illegal request.
- load_data  out  32  extended load result; held until the next load completes.
- mem_addr  out  32  word-aligned byte address ([1:0] = 00).
- mem_wdata  out  32  lane-shifted store data.
- mem_mask  out  4  byte-lane enables.
- mem_cs  out  1  active-low chip select.
- mem_wr_en  out  1  active-low write enable.
- mem_rd_en  out  1  active-high read enable.
- mem_rdata  in  32  memory read word; combinational from mem_addr.

## Operation
- FSM states: IDLE, ACC1, ACC2, FIN.
- IDLE + req_valid:
  - Latch the request.
  - Go to ACC1, or to FIN with err set if illegal.
- Illegal requests:
  - funct3 ∈ {011, 110, 111}.
  - Store with funct3 100 or 101.
- Access size: s = 1, 2 or 4 bytes. off = addr[1:0]. The access crosses a word if off + s > 4.
- ACC1:
  - mem_addr = {addr[31:2], 00}.
  - mem_mask = (((1<<s)-1) << off)[3:0].
  - mem_wdata = wdata << 8·off.
  - mem_cs = 0. For a store, mem_wr_en = 0. For a load, mem_rd_en = 1.
  - Load: capture mem_rdata into hold register lo at the end of the cycle.
  - Next state: ACC2 if crossing, else FIN.
- ACC2:
  - mem_addr = {addr[31:2] + 1, 00}, mod 2^32 (0xFFFFFFFC wraps to 0).
  - mem_mask = ((1<<s)-1) >> (4-off).
  - mem_wdata = wdata >> 8·(4-off).
  - Same controls as ACC1.
  - Load: capture mem_rdata into hi.
  - Next state: FIN.
- Load assembly:
  - Raw bytes are lo lanes off..3, followed by hi lanes 0..(off+s-5).
  - Result takes the low s bytes of the raw bytes.
  - B/H: sign-extend from bit 8s-1. BU/HU: zero-extend. W: no extension.
  - load_data is registered on entry to FIN.
- FIN: done = 1 (err = 1 if illegal). Next state: IDLE.
- Memory idle values (any state other than ACC1/ACC2): mem_cs = 1, mem_wr_en = 1, mem_rd_en = 0, mem_mask = 0000, mem_addr = 0, mem_wdata = 0.
- Memory outputs are registered: the values for ACC1/ACC2 are loaded on the edge that enters that state. The memory commits the write on the falling edge inside that cycle.
- The request inputs are ignored while stall = 1.

## Timing
- Request sampled at the rising edge ending cycle N (IDLE).
- Aligned or non-crossing access:
  - ACC1 in cycle N+1.
  - FIN in N+2: done pulse, load_data valid.
- Crossing access:
  - ACC1 in N+1, ACC2 in N+2.
  - FIN in N+3.
- Illegal request: FIN in N+1 with done = err = 1. No memory activity.
- stall is high from N+1 through FIN inclusive. A new request can be accepted in the cycle after FIN.
- Reset values: state IDLE, stall 0, done 0, err 0, load_data 0, memory outputs at idle values.
- Reset mid-operation:
  - Returns to IDLE on that edge; no done pulse.
  - A store half already written in ACC1 stays committed.
  - load_data keeps its reset value of 0.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF:
  - ACC1 at N+1: mem_addr 0x10, mask 1111, mem_wdata 0xDEADBEEF, cs = 0, wr_en = 0.
  - done at N+2.
- LB addr 0x13, memory word 0x80FFFFFF:
  - Single access, mask 1000.
  - load_data 0xFFFFFF80 at N+2.
  - LBU at the same address gives 0x00000080.
- SH addr 0x0B, wdata 0x0000A1B2, split:
  - ACC1: addr 0x08, mask 1000, mem_wdata 0xB2000000.
  - ACC2: addr 0x0C, mask 0001, mem_wdata 0x000000A1.
  - done at N+3.
- LW addr 0x06, word@4 = 0x44332211, word@8 = 0x88776655:
  - Two reads.
  - load_data 0x66554433 at N+3.
  - stall high for N+1..N+3.
- LW addr 0xFFFFFFFE: ACC2 uses mem_addr 0x00000000.
- Illegal and reset cases:
  - funct3 = 011: done = err = 1 at N+1, mem_cs stays 1.
  - rst asserted during ACC2 of a split store: next cycle IDLE, stall = 0, no done; the first-half bytes are present in memory.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_if
// Description : Request, response and data-memory bus of the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_cs;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, funct3, addr, wdata, mem_rdata,
        output stall, done, err, load_data,
               mem_addr, mem_wdata, mem_mask, mem_cs, mem_wr_en, mem_rd_en
    );

    modport master (
        output req_valid, req_we, funct3, addr, wdata, mem_rdata,
        input  stall, done, err, load_data,
               mem_addr, mem_wdata, mem_mask, mem_cs, mem_wr_en, mem_rd_en
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store unit; splits word-crossing accesses in two.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl (
    input  wire logic  clk,
    input  wire logic  rst,
    lsu_ctrl_if.slave  bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_acc1 = 2'd1;
    localparam logic [1:0] c_st_acc2 = 2'd2;
    localparam logic [1:0] c_st_fin  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_lo;
    logic [31:0] r_load_data;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_mask;
    logic        r_mem_cs;
    logic        r_mem_wr_en;
    logic        r_mem_rd_en;

    // Memory outputs are registered, so the entering edge must use the raw
    // request in IDLE and the latched copy afterwards.
    logic        w_in_idle;
    logic        w_we;
    logic [2:0]  w_funct3;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_off;
    logic [3:0]  w_lanes;
    logic [7:0]  w_span;
    logic [63:0] w_wide;
    logic        w_cross;
    logic        w_illegal;
    logic [31:0] w_lo;
    logic [63:0] w_pair;
    logic [31:0] w_raw;
    logic [31:0] w_ext;

    assign w_in_idle = (r_state == c_st_idle);
    assign w_we      = w_in_idle ? bus.req_we : r_we;
    assign w_funct3  = w_in_idle ? bus.funct3 : r_funct3;
    assign w_addr    = w_in_idle ? bus.addr   : r_addr;
    assign w_wdata   = w_in_idle ? bus.wdata  : r_wdata;
    assign w_off     = w_addr[1:0];

    always_comb begin
        w_lanes = 4'b1111;
        case (w_funct3[1:0])
            2'b00:   w_lanes = 4'b0001;
            2'b01:   w_lanes = 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

    // Upper nibble / word of the shifted span is exactly the second access.
    assign w_span  = {4'b0000, w_lanes} << w_off;
    assign w_wide  = {32'h0, w_wdata} << {w_off, 3'b000};
    assign w_cross = |w_span[7:4];

    assign w_illegal = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11) ||
                       (bus.req_we && bus.funct3[2]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (bus.req_valid) w_next = w_illegal ? c_st_fin : c_st_acc1;
            c_st_acc1: w_next = w_cross ? c_st_acc2 : c_st_fin;
            c_st_acc2: w_next = c_st_fin;
            c_st_fin:  w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    // Non-crossing loads finish from ACC1, where the live word is also lo.
    assign w_lo   = (r_state == c_st_acc1) ? bus.mem_rdata : r_lo;
    assign w_pair = {bus.mem_rdata, w_lo};
    assign w_raw  = w_pair[{r_addr[1:0], 3'b000} +: 32];

    always_comb begin
        w_ext = w_raw;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
            3'b001:  w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
            3'b100:  w_ext = {24'h0, w_raw[7:0]};
            3'b101:  w_ext = {16'h0, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_err       <= 1'b0;
            r_lo        <= 32'h0;
            r_load_data <= 32'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_mask  <= 4'b0000;
            r_mem_cs    <= 1'b1;
            r_mem_wr_en <= 1'b1;
            r_mem_rd_en <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_in_idle && bus.req_valid) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.funct3;
                r_addr   <= bus.addr;
                r_wdata  <= bus.wdata;
                r_err    <= w_illegal;
            end
            if (r_state == c_st_acc1) r_lo <= bus.mem_rdata;
            if ((w_next == c_st_fin) && !r_we &&
                ((r_state == c_st_acc1) || (r_state == c_st_acc2)))
                r_load_data <= w_ext;

            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_mask  <= 4'b0000;
            r_mem_cs    <= 1'b1;
            r_mem_wr_en <= 1'b1;
            r_mem_rd_en <= 1'b0;
            if (w_next == c_st_acc1) begin
                r_mem_addr  <= {w_addr[31:2], 2'b00};
                r_mem_wdata <= w_wide[31:0];
                r_mem_mask  <= w_span[3:0];
                r_mem_cs    <= 1'b0;
                r_mem_wr_en <= ~w_we;
                r_mem_rd_en <= ~w_we;
            end else if (w_next == c_st_acc2) begin
                r_mem_addr  <= {w_addr[31:2] + 30'd1, 2'b00};
                r_mem_wdata <= w_wide[63:32];
                r_mem_mask  <= w_span[7:4];
                r_mem_cs    <= 1'b0;
                r_mem_wr_en <= ~w_we;
                r_mem_rd_en <= ~w_we;
            end
        end
    end

    assign bus.stall     = (r_state != c_st_idle);
    assign bus.done      = (r_state == c_st_fin);
    assign bus.err       = (r_state == c_st_fin) && r_err;
    assign bus.load_data = r_load_data;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_mask  = r_mem_mask;
    assign bus.mem_cs    = r_mem_cs;
    assign bus.mem_wr_en = r_mem_wr_en;
    assign bus.mem_rd_en = r_mem_rd_en;

endmodule
`default_nettype wire
